// File: rtl/dual_slope_sequencer_pkg.sv
// Shared definitions for the dual-slope ADC sequencer and the SPI command decoder:
// sequencer states, default phase timings and analog switch levels.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHORT,
    S_INTEG,
    S_RUNDOWN,
    S_DONE
  } state_t;

  localparam int T_RESET_DEF = 64;
  localparam int T_INT_DEF   = 20000;
  localparam int T_MAX_DEF   = 65535;

  // Switch drive levels as seen at the integrator short switch and DG444 select.
  localparam logic SHORTED  = 1'b0;
  localparam logic RELEASED = 1'b1;
  localparam logic SEL_IN   = 1'b1;
  localparam logic SEL_REF  = 1'b0;

endpackage

// File: rtl/dual_slope_sequencer_if.sv
// Command/readout bundle between the SPI side (master) and the sequencer (slave).
interface dual_slope_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             overrange;
  logic [CNT_W-1:0] result;

  modport master (output start, abort, input busy, done, overrange, result);
  modport slave  (input start, abort, output busy, done, overrange, result);
endinterface

// File: rtl/dual_slope_sequencer_sync_ff2.sv
// Two-flop synchroniser for a single asynchronous input.
module sync_ff2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/dual_slope_sequencer.sv
// Dual-slope ADC conversion sequencer: short, fixed integrate, timed reference run-down.
// All outputs are registered; m_ref is the inverse of the registered input select.
module dual_slope_sequencer
  import adc_seq_pkg::*;
#(
  parameter int T_RESET = T_RESET_DEF,
  parameter int T_INT   = T_INT_DEF,
  parameter int T_MAX   = T_MAX_DEF,
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dual_slope_sequencer_if.slave   bus,
  input  logic                    cmp_in,
  output logic                    m_reset,
  output logic                    m_in,
  output logic                    m_ref
);

  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(T_RESET - 1);
  localparam logic [CNT_W-1:0] INT_LAST   = CNT_W'(T_INT - 1);
  localparam logic [CNT_W-1:0] RD_MAX     = CNT_W'(T_MAX);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             ovr_q;
  logic             m_reset_q;
  logic             m_in_q;
  logic             cmp_s;

  sync_ff2 u_cmp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp_in),
    .q     (cmp_s)
  );

  // NOTE: all state here is updated with non-blocking assignments so every branch
  // reads the pre-edge values; result/counters are plain registers, so resetting them is cheap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      rd_cnt    <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      m_reset_q <= SHORTED;
      m_in_q    <= SEL_REF;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        // Abort leaves result/overrange untouched so the last good reading survives.
        state     <= S_IDLE;
        busy_q    <= 1'b0;
        m_reset_q <= SHORTED;
        m_in_q    <= SEL_REF;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              state     <= S_SHORT;
              phase_cnt <= '0;
              busy_q    <= 1'b1;
            end
          end
          S_SHORT: begin
            if (phase_cnt == RESET_LAST) begin
              state     <= S_INTEG;
              phase_cnt <= '0;
              m_reset_q <= RELEASED;
              m_in_q    <= SEL_IN;
            end else begin
              phase_cnt <= phase_cnt + ONE;
            end
          end
          S_INTEG: begin
            if (phase_cnt == INT_LAST) begin
              state  <= S_RUNDOWN;
              rd_cnt <= '0;
              m_in_q <= SEL_REF;
            end else begin
              phase_cnt <= phase_cnt + ONE;
            end
          end
          S_RUNDOWN: begin
            // Count includes the synchroniser delay; downstream calibration removes it.
            if (!cmp_s) begin
              state     <= S_DONE;
              result_q  <= rd_cnt;
              ovr_q     <= 1'b0;
              done_q    <= 1'b1;
              m_reset_q <= SHORTED;
            end else if (rd_cnt == RD_MAX) begin
              state     <= S_DONE;
              result_q  <= RD_MAX;
              ovr_q     <= 1'b1;
              done_q    <= 1'b1;
              m_reset_q <= SHORTED;
            end else begin
              rd_cnt <= rd_cnt + ONE;
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overrange = ovr_q;
  assign bus.result    = result_q;
  assign m_reset       = m_reset_q;
  assign m_in          = m_in_q;
  assign m_ref         = ~m_in_q;

endmodule

// File: tb/tb_dual_slope_sequencer.sv
// Directed self-checking bench for dual_slope_sequencer with T_RESET=4, T_INT=16, T_MAX=64.
module tb_dual_slope_sequencer;

  localparam int RD_ENTRY = 21;  // first RUNDOWN cycle: 1 + T_RESET + T_INT

  logic clk;
  logic rst_n;
  logic cmp_in;
  logic m_reset;
  logic m_in;
  logic m_ref;

  int n_cmp;
  int n_bad;

  dual_slope_sequencer_if #(.CNT_W(32)) bus ();

  dual_slope_sequencer #(
    .T_RESET (4),
    .T_INT   (16),
    .T_MAX   (64),
    .CNT_W   (32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .cmp_in  (cmp_in),
    .m_reset (m_reset),
    .m_in    (m_in),
    .m_ref   (m_ref)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one conversion from IDLE; called at a negedge (cycle 0 drives start).
  // fall_at >= 0 drops cmp_in in cycle RD_ENTRY+fall_at; restart_at pulses start mid-run.
  task automatic run_conv(input logic cmp_init, input int fall_at, input int restart_at,
                          output int short_len, output int int_len, output int done_cyc,
                          output int n_done, output int idle_cyc, output int ref_err);
    short_len = 0; int_len = 0; done_cyc = -1; n_done = 0; idle_cyc = -1; ref_err = 0;
    cmp_in       = cmp_init;
    bus.start    = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      bus.start = (c == restart_at);
      if (fall_at >= 0 && c == RD_ENTRY + fall_at) cmp_in = 1'b0;
      if (bus.busy && !m_reset && !bus.done) short_len++;
      if (m_in) int_len++;
      if (m_ref !== ~m_in) ref_err++;
      if (bus.done) begin
        n_done++;
        done_cyc = c;
      end
      if (!bus.busy) begin
        idle_cyc = c;
        break;
      end
    end
  endtask

  initial begin
    int sl, il, dc, nd, ic, re, cnt;
    n_cmp = 0;
    n_bad = 0;
    rst_n     = 1'b0;
    cmp_in    = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;

    // Reset values
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_m_reset", 32'(m_reset), 32'd0);
    check("rst_m_in", 32'(m_in), 32'd0);
    check("rst_m_ref", 32'(m_ref), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ovr", 32'(bus.overrange), 32'd0);
    check("rst_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Overrange: comparator never falls
    run_conv(1'b1, -1, -1, sl, il, dc, nd, ic, re);
    check("ovr_short_len", 32'(sl), 32'd4);
    check("ovr_int_len", 32'(il), 32'd16);
    check("ovr_done_cyc", 32'(dc), 32'd86);
    check("ovr_n_done", 32'(nd), 32'd1);
    check("ovr_idle_cyc", 32'(ic), 32'd87);
    check("ovr_result", bus.result, 32'd64);
    check("ovr_flag", 32'(bus.overrange), 32'd1);
    check("ovr_m_ref", 32'(re), 32'd0);
    repeat (2) @(negedge clk);

    // Nominal: cmp falls 10 cycles after RUNDOWN entry, result 12, clears overrange
    run_conv(1'b1, 10, -1, sl, il, dc, nd, ic, re);
    check("nom_short_len", 32'(sl), 32'd4);
    check("nom_int_len", 32'(il), 32'd16);
    check("nom_done_cyc", 32'(dc), 32'd34);
    check("nom_n_done", 32'(nd), 32'd1);
    check("nom_idle_cyc", 32'(ic), 32'd35);
    check("nom_result", bus.result, 32'd12);
    check("nom_ovr", 32'(bus.overrange), 32'd0);
    check("nom_m_ref", 32'(re), 32'd0);
    repeat (2) @(negedge clk);

    // Comparator already low
    run_conv(1'b0, -1, -1, sl, il, dc, nd, ic, re);
    check("low_done_cyc", 32'(dc), 32'd22);
    check("low_n_done", 32'(nd), 32'd1);
    check("low_result", bus.result, 32'd0);
    check("low_ovr", 32'(bus.overrange), 32'd0);
    repeat (2) @(negedge clk);

    // Start pulsed during INTEG is ignored
    run_conv(1'b1, 10, 8, sl, il, dc, nd, ic, re);
    check("ign_short_len", 32'(sl), 32'd4);
    check("ign_int_len", 32'(il), 32'd16);
    check("ign_done_cyc", 32'(dc), 32'd34);
    check("ign_n_done", 32'(nd), 32'd1);
    check("ign_result", bus.result, 32'd12);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.busy || bus.done) cnt++;
    end
    check("ign_no_restart", 32'(cnt), 32'd0);

    // Abort in the 3rd INTEG cycle (cycle 7)
    cmp_in    = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("abt_pre_m_in", 32'(m_in), 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abt_busy", 32'(bus.busy), 32'd0);
    check("abt_m_reset", 32'(m_reset), 32'd0);
    check("abt_m_in", 32'(m_in), 32'd0);
    check("abt_done", 32'(bus.done), 32'd0);
    check("abt_result", bus.result, 32'd12);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.busy || bus.done) cnt++;
    end
    check("abt_stays_idle", 32'(cnt), 32'd0);

    // start and abort together in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("sa_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("sa_busy_next", 32'(bus.busy), 32'd0);
    check("sa_m_reset", 32'(m_reset), 32'd0);

    // Asynchronous reset mid-RUNDOWN
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (24) @(negedge clk);
    check("ar_pre_busy", 32'(bus.busy), 32'd1);
    check("ar_pre_m_reset", 32'(m_reset), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", 32'(bus.busy), 32'd0);
    check("ar_m_reset", 32'(m_reset), 32'd0);
    check("ar_m_in", 32'(m_in), 32'd0);
    check("ar_m_ref", 32'(m_ref), 32'd1);
    check("ar_result", bus.result, 32'd0);
    check("ar_ovr", 32'(bus.overrange), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dual_slope_sequencer.md
# dual_slope_sequencer

Autonomous conversion sequencer for the dual-slope integrating ADC front end. It drives the integrator short switch (m_reset) and the DG444 input/reference select (m_in/m_ref) through reset, fixed-time integrate and reference run-down phases, and times the run-down from the synchronised comparator. It sits between the SPI command decoder, which supplies `start`/`abort`, and the SPI readout shift register, which consumes `result`/`done`.

## Interface
- `T_RESET`, 64: cycles the integrator cap is held shorted before integration (≥1).
- `T_INT`, 20000: fixed integrate cycles on the input (≥1).
- `T_MAX`, 65535: run-down cycle limit before overrange (≥1).
- `CNT_W`, 32: width of `result` and internal counters (must hold max(T_RESET, T_INT, T_MAX)).
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request, synchronous to `clk`; honoured only in IDLE.
- `abort` in 1: synchronous; returns the block to IDLE from any state.
- `cmp_in` in 1: integrator zero-cross comparator; asynchronous; high while the integrator is above zero.
- `m_reset` out 1: 0 = cap shorted, 1 = integrator released.
- `m_in` out 1: 1 = input selected.
- `m_ref` out 1: always `!m_in`; 1 = reference selected.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: single-cycle pulse when a conversion completes.
- `overrange` out 1: set at `done` if the run-down hit `T_MAX`.
- `result` out CNT_W: run-down cycle count, held until the next `done`.

## Operation
- States: IDLE, SHORT, INTEG, RUNDOWN, DONE.
- IDLE: `m_reset`=0, `m_in`=0. `start`=1 → SHORT; the phase counter is cleared to 0.
- SHORT: `m_reset`=0, `m_in`=0. Lasts exactly `T_RESET` cycles, then → INTEG with the counter cleared.
- INTEG: `m_reset`=1, `m_in`=1. Lasts exactly `T_INT` cycles, then → RUNDOWN with the run-down counter at 0.
- RUNDOWN: `m_reset`=1, `m_in`=0. Each cycle the block evaluates the synchronised comparator `cmp_s`:
  - `cmp_s`=0: latch `result` ← run-down count, clear `overrange`, → DONE.
  - Otherwise, if count == `T_MAX`: `result` ← `T_MAX`, set `overrange`, → DONE.
  - Otherwise, count increments.
- DONE: `done`=1 for this one cycle, `m_reset`=0, → IDLE.
- `cmp_s` is `cmp_in` through a 2-flop synchroniser. `result` includes the 2-cycle synchroniser latency; the block does not compensate for it.
- If `cmp_s` is already 0 on the first RUNDOWN cycle, `result`=0.
- `start` outside IDLE is ignored; it is not queued.
- `abort` has priority over every transition. It sends the block to IDLE next cycle, with `m_reset`=0 and `m_in`=0, and no `done`. `result` and `overrange` keep their previous values.
- `start` and `abort` in the same cycle: `abort` wins, and the block stays in IDLE.

## Timing
- Reset values: state IDLE, `m_reset`=0, `m_in`=0, `m_ref`=1, `busy`=0, `done`=0, `overrange`=0, `result`=0, synchroniser flops=0.
- All outputs are registered, except `m_ref`, which is a combinational inversion of registered `m_in`.
- `start` at cycle 0 → `busy`=1 at cycle 1. `m_reset` rises at cycle 1+`T_RESET`. `m_in` falls at cycle 1+`T_RESET`+`T_INT`.
- Conversion length is 1+`T_RESET`+`T_INT`+N+1 cycles, where N is the `result` value (or `T_MAX` on overrange).
- `done`, `result` and `overrange` update in the same cycle. `busy` is 0 in the cycle after `done`.
- `rst_n` asserted mid-conversion forces the reset values immediately. With the switches in their reset state, the cap is shorted.

## Structure
- Shared package `adc_seq_pkg` holds:
  - the state enum;
  - default values for `T_RESET`, `T_INT` and `T_MAX`;
  - the switch-level constants (SHORTED=0, RELEASED=1, SEL_IN=1, SEL_REF=0), which the SPI decoder also uses.
- One sub-module, `sync_ff2`: a 2-flop synchroniser with asynchronous active-low reset, used for `cmp_in`.
- Counters: one phase counter shared by SHORT and INTEG, and a separate run-down counter.

## Test plan
All cases use `T_RESET`=4, `T_INT`=16, `T_MAX`=64.
- **Nominal conversion:** `start` pulse; `cmp_in` falls 10 cycles after RUNDOWN entry → `m_reset` low for 4 cycles, `m_in` high for 16 cycles, `done` pulse, `result`=12 (10 + 2 sync), `overrange`=0.
- **Comparator already low:** `cmp_in` held 0 throughout → `result`=0, `done` on the 1st cycle after RUNDOWN entry, `overrange`=0.
- **Overrange:** `cmp_in` held 1 → `result`=64, `overrange`=1, `done` 65 cycles after RUNDOWN entry; a following normal conversion clears `overrange`.
- **Start ignored while busy:** `start` pulsed during INTEG → no restart, exactly one `done`, phase lengths unchanged.
- **Abort:** `abort` in the 3rd INTEG cycle → next cycle IDLE, `m_reset`=0, `m_in`=0, `busy`=0, no `done`, `result` unchanged. `start`+`abort` together in IDLE → stays IDLE.
- **Async reset:** `rst_n` pulsed low mid-RUNDOWN → outputs take reset values without waiting for a clock edge; `result`=0.
